hci_datamover_cfg_sequencer: RTL

//   Hardware master for the hwpe_ctrl_intf_periph register port of one datamover. Sits directly

---
 rtl/hci_datamover_cfg_sequencer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/hci_datamover_cfg_sequencer.sv
// hci_datamover_cfg_sequencer
// Hardware master for one datamover's periph register port. It forwards a stream of
// (offset, data) configuration writes, writes the trigger register, then polls the
// status register until the job finishes. It reports an error on a poll timeout or on
// an unexpected response id.
//
// Handshakes:
//   cmd    : a command transfers on a rising clk edge where cmd_valid_i && cmd_ready_o.
//            cmd_ready_o is registered and is high only in the CMD state.
//   periph : a request transfers on a rising clk edge where periph_req_o && periph_gnt_i.
//            add/wen/data/be are held stable while req is high. Only one transaction is
//            outstanding. A read response is accepted only in RDRSP, which is entered the
//            cycle after the read grant.
module hci_datamover_cfg_sequencer #(
  parameter int unsigned ID_PERIPH       = 8,
  parameter logic [31:0] TRIGGER_OFFSET  = 32'h0000_0000,
  parameter logic [31:0] STATUS_OFFSET   = 32'h0000_000C,
  parameter int unsigned STATUS_BUSY_BIT = 0,
  parameter int unsigned POLL_GAP        = 4,
  parameter int unsigned MAX_POLLS       = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [31:0]          base_addr_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [31:0]          status_o,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [31:0]          cmd_offset_i,
  input  logic [31:0]          cmd_data_i,
  input  logic                 cmd_last_i,
  output logic                 periph_req_o,
  input  logic                 periph_gnt_i,
  output logic [31:0]          periph_add_o,
  output logic                 periph_wen_o,
  output logic [3:0]           periph_be_o,
  output logic [31:0]          periph_data_o,
  output logic [ID_PERIPH-1:0] periph_id_o,
  input  logic [31:0]          periph_r_data_i,
  input  logic                 periph_r_valid_i,
  input  logic [ID_PERIPH-1:0] periph_r_id_i
);

  localparam int unsigned PW = $clog2(MAX_POLLS + 1);
  localparam int unsigned GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [PW-1:0] POLL_LIMIT = PW'(MAX_POLLS);
  localparam logic [GW-1:0] GAP_LAST   = GW'(POLL_GAP - 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_CMD   = 4'd1,
    S_WR    = 4'd2,
    S_TRIG  = 4'd3,
    S_GAP   = 4'd4,
    S_RDREQ = 4'd5,
    S_RDRSP = 4'd6,
    S_DONE  = 4'd7,
    S_ERR   = 4'd8
  } state_t;

  // state_q is the FSM state; kept as a plainly named enum so checkers can bind to it
  state_t        state_q;
  logic [31:0]   base_q;
  logic          last_q;
  logic [PW-1:0] poll_cnt_q;
  logic [GW-1:0] gap_cnt_q;
  logic [PW-1:0] poll_nxt;

  // The response id is fixed; the sequencer only ever issues id 0
  assign periph_id_o = '0;

  // Poll count after the response currently being accepted
  always_comb begin
    poll_nxt = poll_cnt_q + PW'(1);
  end

  // Sequencer FSM; every output it drives is registered here
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      base_q        <= '0;
      last_q        <= 1'b0;
      poll_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      error_o       <= 1'b0;
      status_o      <= '0;
      cmd_ready_o   <= 1'b0;
      periph_req_o  <= 1'b0;
      periph_add_o  <= '0;
      periph_wen_o  <= 1'b1;
      periph_be_o   <= 4'b0000;
      periph_data_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            base_q      <= base_addr_i;
            error_o     <= 1'b0;
            busy_o      <= 1'b1;
            cmd_ready_o <= 1'b1;
            state_q     <= S_CMD;
          end
        end
        S_CMD: begin
          if (cmd_valid_i && cmd_ready_o) begin
            periph_req_o  <= 1'b1;
            periph_be_o   <= 4'b1111;
            periph_wen_o  <= 1'b0;
            periph_add_o  <= base_q + cmd_offset_i;
            periph_data_o <= cmd_data_i;
            last_q        <= cmd_last_i;
            cmd_ready_o   <= 1'b0;
            state_q       <= S_WR;
          end
        end
        S_WR: begin
          if (periph_gnt_i) begin
            if (last_q) begin
              // Trigger write goes out back-to-back with the final config write
              periph_add_o  <= base_q + TRIGGER_OFFSET;
              periph_data_o <= '0;
              periph_wen_o  <= 1'b0;
              state_q       <= S_TRIG;
            end else begin
              periph_req_o <= 1'b0;
              periph_be_o  <= 4'b0000;
              cmd_ready_o  <= 1'b1;
              state_q      <= S_CMD;
            end
          end
        end
        S_TRIG: begin
          if (periph_gnt_i) begin
            periph_req_o <= 1'b0;
            periph_be_o  <= 4'b0000;
            poll_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            state_q      <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            periph_req_o  <= 1'b1;
            periph_be_o   <= 4'b1111;
            periph_wen_o  <= 1'b1;
            periph_add_o  <= base_q + STATUS_OFFSET;
            periph_data_o <= '0;
            state_q       <= S_RDREQ;
          end else begin
            gap_cnt_q <= gap_cnt_q + GW'(1);
          end
        end
        S_RDREQ: begin
          if (periph_gnt_i) begin
            periph_req_o <= 1'b0;
            periph_be_o  <= 4'b0000;
            state_q      <= S_RDRSP;
          end
        end
        S_RDRSP: begin
          if (periph_r_valid_i) begin
            status_o   <= periph_r_data_i;
            poll_cnt_q <= poll_nxt;
            if (periph_r_id_i != '0) begin
              error_o <= 1'b1;
              state_q <= S_ERR;
            end else if (!periph_r_data_i[STATUS_BUSY_BIT]) begin
              done_o  <= 1'b1;
              state_q <= S_DONE;
            end else if (poll_nxt == POLL_LIMIT) begin
              error_o <= 1'b1;
              state_q <= S_ERR;
            end else begin
              gap_cnt_q <= '0;
              state_q   <= S_GAP;
            end
          end
        end
        S_DONE: begin
          busy_o  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_ERR: begin
          busy_o  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
